// File: rtl/pbus_pkg.sv
// Shared opcodes, FSM state encoding and status-byte packing for the
// byte-serial register/stream command engine.
package pbus_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h05;
    localparam logic [7:0] OP_STREAM = 8'h80;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_STREAM,
        ST_DROP
    } state_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                               input logic empty, input logic [3:0] lvl);
        return {ovf, full, empty, 1'b0, lvl};
    endfunction

endpackage

// File: rtl/pbus_stream_fifo.sv
// Byte-wide synchronous FIFO for the stream path; a push while full is
// accepted only when a pop completes in the same cycle.
module pbus_stream_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pbus_cmd_engine.sv
// Byte-serial command engine: decodes framed commands into register-file
// strobes, streams read-back bytes in bursts, and feeds a stream FIFO.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_CMD    | waiting for an opcode byte
//   ST_ADDR   | next byte is the register address (WRITE or READ)
//   ST_WDATA  | collecting write bytes, little-endian
//   ST_RDATA  | driving read-back bytes (register burst or status)
//   ST_STREAM | next byte goes to the stream FIFO
//   ST_DROP   | unknown opcode, ignore bytes until the frame ends
module pbus_cmd_engine
    import pbus_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_BYTES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    cs_n,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic                    dout_valid,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    output logic                    reg_we,
    output logic                    reg_re,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    output logic [7:0]              strm_data,
    output logic                    strm_valid,
    input  logic                    strm_ready,
    output logic                    overflow
);
    localparam int            DW   = 8 * DATA_BYTES;
    localparam int            IW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int            LW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] LAST = IW'(DATA_BYTES - 1);

    logic [1:0]    rst_sync;
    logic          run;
    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          wr_last;
    logic          rd_load;
    logic          op_read;
    logic          rd_status;
    logic          first;
    logic [IW-1:0] wcnt;
    logic [IW-1:0] byte_idx;
    logic [IW-1:0] cur_idx;
    logic [DW-1:0] wbuf;
    logic [DW-1:0] wword;
    logic [DW-1:0] word;
    logic [DW-1:0] src_word;
    logic [7:0]    rd_byte;
    logic          push;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [3:0]    lvl4;

    // Reset asserts asynchronously; byte acceptance resumes two clocks after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign accept     = run && ena && !cs_n;
    assign push       = (state == ST_STREAM) && accept;
    assign strm_valid = !fifo_empty;
    assign pop        = strm_valid && strm_ready;
    assign drop       = push && fifo_full && !pop;
    assign lvl4       = 4'(fifo_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= ST_CMD;
        else if (!run) state <= ST_CMD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_n) begin
            state_nxt = ST_CMD;
        end else if (accept) begin
            case (state)
                ST_CMD: begin
                    case (din)
                        OP_WRITE, OP_READ: state_nxt = ST_ADDR;
                        OP_STREAM:         state_nxt = ST_STREAM;
                        OP_STATUS:         state_nxt = ST_RDATA;
                        default:           state_nxt = ST_DROP;
                    endcase
                end
                ST_ADDR:   state_nxt = op_read ? ST_RDATA : ST_WDATA;
                ST_WDATA:  if (wcnt == LAST) state_nxt = ST_CMD;
                ST_STREAM: state_nxt = ST_CMD;
                default:   ;
            endcase
        end
    end

    // The first read-back byte loads unconditionally in the strobe cycle; later ones per accepted byte.
    always_comb begin
        wr_last  = (state == ST_WDATA) && accept && (wcnt == LAST);
        rd_load  = run && !cs_n && (state == ST_RDATA) && (first || ena);
        cur_idx  = reg_re ? '0 : byte_idx;
        src_word = reg_re ? reg_rdata : word;
        rd_byte  = rd_status ? status_byte(overflow, fifo_full, fifo_empty, lvl4)
                             : src_word[{cur_idx, 3'b000} +: 8];
        wword    = wbuf;
        wword[{wcnt, 3'b000} +: 8] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            overflow   <= 1'b0;
            op_read    <= 1'b0;
            rd_status  <= 1'b0;
            first      <= 1'b0;
            wcnt       <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
            word       <= '0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (cs_n) dout_valid <= 1'b0;
            if (accept) begin
                case (state)
                    ST_CMD: begin
                        op_read   <= (din == OP_READ);
                        rd_status <= (din == OP_STATUS);
                        first     <= 1'b1;
                        wcnt      <= '0;
                    end
                    ST_ADDR: begin
                        reg_addr <= din[ADDR_W-1:0];
                        reg_re   <= op_read;
                    end
                    ST_WDATA: begin
                        wbuf <= wword;
                        wcnt <= wr_last ? '0 : wcnt + IW'(1);
                        if (wr_last) begin
                            reg_wdata <= wword;
                            reg_we    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (reg_re) word <= reg_rdata;
            if (rd_load) begin
                dout       <= rd_byte;
                dout_valid <= 1'b1;
                first      <= 1'b0;
                byte_idx   <= (cur_idx == LAST) ? '0 : cur_idx + IW'(1);
                if (!rd_status && (cur_idx == LAST)) begin
                    reg_re   <= 1'b1;
                    reg_addr <= reg_addr + ADDR_W'(1);
                end
            end else if (reg_re) begin
                byte_idx <= '0;
            end
            if (drop)                       overflow <= 1'b1;
            else if (rd_load && rd_status)  overflow <= 1'b0;
        end
    end

    pbus_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (din),
        .pop       (pop),
        .pop_data  (strm_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_pbus_cmd_engine.sv
// Directed plus randomized bench for pbus_cmd_engine (16-bit registers,
// 4-entry FIFO) against a register-array / byte-queue reference model.
module tb_pbus_cmd_engine;
    localparam int ADDR_W     = 8;
    localparam int DATA_BYTES = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cs_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic [7:0]  strm_data;
    logic        strm_valid;
    logic        strm_ready;
    logic        overflow;

    logic [15:0] regs [256];
    logic [7:0]  q [$];
    logic        ovf_m;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_seen  = 0;
    int          exp_we   = 0;

    always #5 clk = ~clk;
    assign reg_rdata = regs[reg_addr];

    pbus_cmd_engine #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cs_n       (cs_n),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .strm_data  (strm_data),
        .strm_valid (strm_valid),
        .strm_ready (strm_ready),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && reg_we) we_seen = we_seen + 1;
        if (rst_n && (reg_we || reg_re)) check("we_re_exclusive", reg_we & reg_re, 0);
    end

    function automatic int st();
        return $urandom_range(0, 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            cs_n = 1'b0; ena = 1'b0; din = 8'($urandom); tick();
        end
        cs_n = 1'b0; ena = 1'b1; din = b; tick();
    endtask

    task automatic frame_end();
        cs_n = 1'b1; ena = 1'($urandom_range(0, 1)); din = 8'($urandom); tick();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        send(8'h02, st()); send(a, st()); send(d[7:0], st()); send(d[15:8], st());
        check("wr_we", reg_we, 1);
        check("wr_addr", reg_addr, a);
        check("wr_data", reg_wdata, d);
        regs[a] = d;
        exp_we  = exp_we + 1;
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        logic [7:0]  ad;
        logic [15:0] w;
        send(8'h03, st()); send(a, st());
        check("rd_re", reg_re, 1);
        check("rd_addr", reg_addr, a);
        check("rd_latency", dout_valid, 0);
        ena = 1'b1; din = 8'($urandom); tick();
        for (int j = 0; j < n; j++) begin
            ad = a + 8'(j / 2);
            w  = regs[ad];
            check("rd_byte", dout, (j % 2 == 1) ? w[15:8] : w[7:0]);
            check("rd_valid", dout_valid, 1);
            din = 8'($urandom); tick();
        end
        frame_end();
        check("rd_end_valid", dout_valid, 0);
    endtask

    task automatic push_stream(input logic [7:0] b);
        send(8'h80, st()); send(b, st());
        if (q.size() < FIFO_DEPTH) q.push_back(b);
        else ovf_m = 1'b1;
        check("push_overflow", overflow, ovf_m);
        check("push_valid", strm_valid, 1);
    endtask

    task automatic do_status();
        logic [7:0] e;
        send(8'h05, st());
        ena = 1'b1; din = 8'($urandom); tick();
        e = {ovf_m, q.size() == FIFO_DEPTH, q.size() == 0, 1'b0, 4'(q.size())};
        check("status_b0", dout, e);
        check("status_valid", dout_valid, 1);
        ovf_m = 1'b0;
        check("status_ovf_clr", overflow, 0);
        din = 8'($urandom); tick();
        e = {ovf_m, q.size() == FIFO_DEPTH, q.size() == 0, 1'b0, 4'(q.size())};
        check("status_b1", dout, e);
        frame_end();
        check("status_end_valid", dout_valid, 0);
    endtask

    task automatic drain();
        int i = 0;
        cs_n = 1'b1; ena = 1'b0;
        while (q.size() > 0 && i < 60) begin
            strm_ready = 1'($urandom_range(0, 1));
            check("strm_valid", strm_valid, 1);
            if (strm_ready) begin
                check("strm_data", strm_data, q[0]);
                void'(q.pop_front());
            end
            tick();
            i++;
        end
        strm_ready = 1'b0;
        check("drain_done", q.size(), 0);
        check("strm_empty", strm_valid, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0; #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_reg_re", reg_re, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_strm_valid", strm_valid, 0);
        check("rst_overflow", overflow, 0);
        q.delete();
        ovf_m = 1'b0;
        cs_n = 1'b1; ena = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) regs[i] = 16'($urandom);
        rst_n = 1'b0; ena = 1'b0; cs_n = 1'b1; din = 8'h00; strm_ready = 1'b0; ovf_m = 1'b0;
        repeat (2) tick();
        check("reset_dout", dout, 0);
        check("reset_dout_valid", dout_valid, 0);
        check("reset_reg_addr", reg_addr, 0);
        check("reset_reg_wdata", reg_wdata, 0);
        check("reset_reg_we", reg_we, 0);
        check("reset_reg_re", reg_re, 0);
        check("reset_overflow", overflow, 0);
        check("reset_strm_valid", strm_valid, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Burst across a word boundary, then across the address wrap.
        regs[8'h0F] = 16'hBEEF;
        regs[8'h10] = 16'h1234;
        do_read(8'h0F, 4);
        do_read(8'hFF, 6);

        // Back-to-back writes within one frame.
        do_write(8'h00, 16'h0061);
        do_write(8'h01, 16'h0062);
        frame_end();
        do_read(8'h00, 4);

        // Fill past capacity, status clears overflow, then drain in order.
        for (int i = 0; i < 5; i++) push_stream(8'h61 + 8'(i));
        frame_end();
        do_status();
        drain();

        // Push into a full FIFO while it pops in the same cycle.
        for (int i = 0; i < 4; i++) push_stream(8'($urandom));
        send(8'h80, 0);
        strm_ready = 1'b1;
        send(8'hA5, 0);
        strm_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(8'hA5);
        check("push_pop_full_ovf", overflow, 0);
        frame_end();
        do_status();
        drain();

        // Aborted partial write (cs_n with ena low), then a clean one.
        send(8'h02, 0); send(8'h08, 0); send(8'h77, 0);
        cs_n = 1'b1; ena = 1'b0; tick(); tick();
        check("abort_no_we", we_seen, exp_we);
        do_write(8'h08, 16'h0001);
        frame_end();

        // Unknown opcode swallows the rest of the frame.
        send(8'h7F, 0); send(8'h02, 1); send(8'h00, 0); send(8'hAA, 2); send(8'hBB, 0);
        frame_end(); tick();
        check("drop_no_we", we_seen, exp_we);
        do_write(8'h00, 16'hBBAA);
        frame_end();

        // Reset in the middle of a write.
        send(8'h02, 0); send(8'h20, 0); send(8'h55, 0);
        reset_pulse();
        check("rst_write_no_we", we_seen, exp_we);

        // Reset in the middle of a read burst with data in the FIFO.
        push_stream(8'h33);
        frame_end();
        send(8'h03, 0); send(8'h40, 0);
        ena = 1'b1; repeat (3) tick();
        check("burst_active", dout_valid, 1);
        reset_pulse();

        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int w = 0; w < int'($urandom_range(1, 2)); w++)
                        do_write(8'($urandom_range(0, 15)), 16'($urandom));
                    frame_end();
                end
                1: begin
                    a = (f % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 15));
                    do_read(a, $urandom_range(1, 6));
                end
                default: begin
                    for (int s = 0; s < int'($urandom_range(1, 3)); s++) push_stream(8'($urandom));
                    frame_end();
                    if ($urandom_range(0, 1) == 1) do_status();
                    if ($urandom_range(0, 1) == 1) drain();
                end
            endcase
        end
        do_status();
        drain();
        repeat (2) tick();
        check("we_count", we_seen, exp_we);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pbus_cmd_engine.md
PBUS_CMD_ENGINE -- requirements
Module: pbus_cmd_engine

Interface
REQ-001 Parameter ADDR_W, default 8, register address width (1..8).
REQ-002 Parameter DATA_BYTES, default 1, register width in bytes (1..4); DW = 8*DATA_BYTES.
REQ-003 Parameter FIFO_DEPTH, default 4, stream FIFO entries (power of 2, 2..16).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ena  in  1  input enable; 0 means din/cs_n are ignored.
REQ-007 cs_n  in  1  active-low frame select.
REQ-008 din  in  8  one command/address/data byte per enabled cycle.
REQ-009 dout  out  8  read-back byte.
REQ-010 dout_valid  out  1  dout carries a valid byte this cycle.
REQ-011 reg_addr  out  ADDR_W  register-file address.
REQ-012 reg_wdata  out  DW  register write data.
REQ-013 reg_we  out  1  one-cycle write strobe.
REQ-014 reg_re  out  1  one-cycle read strobe.
REQ-015 reg_rdata  in  DW  read data, combinationally valid in the reg_re cycle.
REQ-016 strm_data / strm_valid / strm_ready  out 8 / out 1 / in 1  stream FIFO output, valid/ready.
REQ-017 overflow  out  1  sticky: stream byte dropped because the FIFO was full.

Function
REQ-018 A byte is accepted in a cycle iff ena=1 and cs_n=0; otherwise the FSM holds state (except REQ-019).
REQ-019 cs_n=1 (with any ena) forces state CMD next cycle, discards partial words, and clears dout_valid.
REQ-020 States: CMD, ADDR, WDATA, RDATA, STREAM, DROP.
REQ-021 CMD: 0x02 (WRITE) -> ADDR; 0x03 (READ) -> ADDR; 0x80 (STREAM) -> STREAM; 0x05 (STATUS) -> RDATA with status source; any other -> DROP.
REQ-022 ADDR: latch din[ADDR_W-1:0] into reg_addr; WRITE -> WDATA, READ -> RDATA.
REQ-023 WDATA: accept DATA_BYTES bytes little-endian; on the last byte assert reg_we for one cycle with the full word, then return to CMD (back-to-back commands within one frame allowed).
REQ-024 READ: reg_re pulses the cycle after the address byte; reg_rdata captured; byte 0 on dout with dout_valid=1 the following cycle (address-to-first-byte latency 2 cycles); bytes advance one per enabled cycle.
REQ-025 READ burst: after the last byte of a word, reg_addr increments (wraps modulo 2^ADDR_W) and a new reg_re issues so the next word's byte 0 follows without a gap; burst ends only on cs_n=1.
REQ-026 RDATA does not interpret din as commands.
REQ-027 STATUS byte = {overflow, FIFO full, FIFO empty, 0, level[3:0]}, refreshed per byte, repeated until cs_n=1.
REQ-028 STREAM: next accepted byte is pushed to the FIFO, then return to CMD.
REQ-029 Push when full: byte dropped, overflow set; overflow clears only on reset or a STATUS read.
REQ-030 Simultaneous push and pop with FIFO full: pop completes, push is accepted.
REQ-031 strm_valid = FIFO not empty; pop on strm_valid & strm_ready; output side independent of ena and cs_n.
REQ-032 DROP: ignore bytes until cs_n=1.
REQ-033 reg_we and reg_re are never asserted in the same cycle.

Reset
REQ-034 On rst_n=0: state CMD; dout, dout_valid, reg_addr, reg_wdata, reg_we, reg_re, overflow all 0; FIFO empty (strm_valid=0).
REQ-035 Reset mid-write produces no reg_we; release is synchronised internally (two flops).

Structure
REQ-036 Package pbus_pkg holds the opcode constants (0x02, 0x03, 0x05, 0x80) and the FSM state enum.
REQ-037 Sub-module pbus_stream_fifo (parametrised depth, width 8, level/full/empty outputs) implements the FIFO.

Verification
REQ-038 DATA_BYTES=1: frame 02 00 61, 02 01 62 -> reg_we twice: addr 0x00 data 0x61, addr 0x01 data 0x62.
REQ-039 DATA_BYTES=2: 03 0F, regs 0x0F=0xBEEF, 0x10=0x1234 -> dout EF BE 34 12 consecutive, first byte 2 cycles after address.
REQ-040 strm_ready=0, FIFO_DEPTH=4: 80 61 80 62 80 63 80 64 80 65 -> FIFO holds 61..64, 0x65 dropped, overflow=1; STATUS read returns 0xC4, then overflow=0.
REQ-041 cs_n raised after 02 08 (DATA_BYTES=2, one data byte sent) -> no reg_we; next frame 02 08 01 00 writes 0x0001.
REQ-042 Unknown opcode 0x7F then 02 00 AA in same frame -> no reg_we until cs_n toggles.
REQ-043 rst_n low during READ burst -> dout_valid=0, reg_re=0 immediately; FIFO empty.
